rx_link_control: RTL and testbench

- Receive-side JESD204B link-layer controller; counterpart of the TX link FSM.
- Sits after the 8b/10b decoder on one lane.
- Runs code group synchronization (CGS) and drives SYNC~ (o_sync_n); detects ILA start, times the ILA, then qualifies user data.
- Requests resynchronization on upper-layer request or on persistent decode errors.

---
 rtl/jesd_link_pkg.sv | 15 +
 rtl/rx_char_detect.sv | 22 ++
 rtl/rx_link_control.sv | 141 ++++++++++++++
 tb/tb_rx_link_control.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/jesd_link_pkg.sv
// Shared JESD204B link-layer definitions: receive FSM state encoding and
// control character codes used by both the RX and TX link controllers.
package jesd_link_pkg;

    typedef enum logic [3:0] {
        RX_CS_INIT  = 4'b0001,
        RX_CS_CHECK = 4'b0010,
        RX_ILA      = 4'b0100,
        RX_DATA     = 4'b1000
    } rx_state_e;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_0 = 8'h1C;

endpackage

// File: rtl/rx_char_detect.sv
// Combinational decode of /K/ (K28.5), /R/ (K28.0) and code errors on one
// decoded octet. Characters carrying a code error are never recognised.
module rx_char_detect
    import jesd_link_pkg::*;
(
    input  logic [7:0] i_octet,
    input  logic       i_is_k,
    input  logic       i_code_err,
    input  logic       i_octet_valid,
    output logic       o_kchar,
    output logic       o_rchar,
    output logic       o_err
);

    logic ctrl_ok;

    assign ctrl_ok = i_octet_valid & i_is_k & ~i_code_err;
    assign o_kchar = ctrl_ok & (i_octet == K28_5);
    assign o_rchar = ctrl_ok & (i_octet == K28_0);
    assign o_err   = i_octet_valid & i_code_err;

endmodule

// File: rtl/rx_link_control.sv
// JESD204B receive link-layer controller for one lane: CGS with SYNC~,
// ILA timing against LMFC, user-data qualification and error-driven resync.
module rx_link_control
    import jesd_link_pkg::*;
#(
    parameter int K_DET_COUNT     = 4,
    parameter int SYNC_MIN_FRAMES = 5,
    parameter int ERR_THRESH      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_clk,
    input  logic       lmfc_clk,
    input  logic [7:0] i_octet,
    input  logic       i_is_k,
    input  logic       i_code_err,
    input  logic       i_octet_valid,
    input  logic       i_sync_request,
    input  logic [7:0] i_ila_multiframe_length,
    output logic       o_sync_n,
    output logic [3:0] o_rx_state,
    output logic       o_ila_valid,
    output logic       o_data_valid,
    output logic [7:0] o_data,
    output logic [7:0] o_err_total
);

    localparam logic [3:0] K_MAX   = 4'(K_DET_COUNT);
    localparam logic [3:0] F_MIN   = 4'(SYNC_MIN_FRAMES);
    localparam logic [1:0] EC_TRIP = 2'(ERR_THRESH - 1);

    rx_state_e  state_q, state_d;
    logic [3:0] k_cnt_q, k_cnt_d;
    logic [3:0] sync_fcnt_q, sync_fcnt_d;
    logic [8:0] mf_cnt_q, mf_cnt_d;
    logic [1:0] ec_q, ec_d;
    logic       sync_n_q, ila_valid_q, data_valid_q;
    logic [7:0] data_q, err_total_q;

    logic kchar, rchar, err, good, resync;

    rx_char_detect u_char_detect (
        .i_octet       (i_octet),
        .i_is_k        (i_is_k),
        .i_code_err    (i_code_err),
        .i_octet_valid (i_octet_valid),
        .o_kchar       (kchar),
        .o_rchar       (rchar),
        .o_err         (err)
    );

    assign good   = i_octet_valid & ~i_code_err;
    assign resync = i_sync_request | (err & (ec_q == EC_TRIP));

    always_comb begin
        state_d     = state_q;
        k_cnt_d     = k_cnt_q;
        sync_fcnt_d = sync_fcnt_q;
        mf_cnt_d    = mf_cnt_q;
        ec_d        = ec_q;

        if (err && ec_q != 2'd3) begin
            ec_d = ec_q + 2'd1;
        end else if (good) begin
            ec_d = 2'd0;
        end

        case (state_q)
            RX_CS_INIT: begin
                if (kchar) begin
                    if (k_cnt_q < K_MAX) k_cnt_d = k_cnt_q + 4'd1;
                end else if (i_octet_valid) begin
                    k_cnt_d = 4'd0;
                end
                if (frame_clk && sync_fcnt_q != 4'hF) sync_fcnt_d = sync_fcnt_q + 4'd1;
                if (k_cnt_q >= K_MAX && sync_fcnt_q >= F_MIN && !i_sync_request)
                    state_d = RX_CS_CHECK;
            end
            RX_CS_CHECK: begin
                if (resync)     state_d = RX_CS_INIT;
                else if (rchar) state_d = RX_ILA;
            end
            RX_ILA: begin
                if (lmfc_clk) mf_cnt_d = mf_cnt_q + 9'd1;
                if (resync)
                    state_d = RX_CS_INIT;
                else if (lmfc_clk && mf_cnt_q == {1'b0, i_ila_multiframe_length})
                    state_d = RX_DATA;
            end
            RX_DATA: begin
                if (resync) state_d = RX_CS_INIT;
            end
            default: state_d = RX_CS_INIT;
        endcase

        // Entry actions override the per-state counter updates above.
        if (state_d != state_q) begin
            if (state_d == RX_CS_INIT) begin
                k_cnt_d     = 4'd0;
                sync_fcnt_d = 4'd0;
                ec_d        = 2'd0;
            end
            if (state_d == RX_ILA) mf_cnt_d = 9'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RX_CS_INIT;
            k_cnt_q      <= 4'd0;
            sync_fcnt_q  <= 4'd0;
            mf_cnt_q     <= 9'd0;
            ec_q         <= 2'd0;
            sync_n_q     <= 1'b0;
            ila_valid_q  <= 1'b0;
            data_valid_q <= 1'b0;
            data_q       <= 8'd0;
            err_total_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            k_cnt_q      <= k_cnt_d;
            sync_fcnt_q  <= sync_fcnt_d;
            mf_cnt_q     <= mf_cnt_d;
            ec_q         <= ec_d;
            // Qualifiers follow the next state so they line up with o_rx_state.
            sync_n_q     <= (state_d != RX_CS_INIT);
            ila_valid_q  <= (state_d == RX_ILA) & good;
            data_valid_q <= (state_d == RX_DATA) & good;
            if (i_octet_valid) data_q <= i_octet;
            if (err && err_total_q != 8'hFF) err_total_q <= err_total_q + 8'd1;
        end
    end

    assign o_sync_n     = sync_n_q;
    assign o_rx_state   = state_q;
    assign o_ila_valid  = ila_valid_q;
    assign o_data_valid = data_valid_q;
    assign o_data       = data_q;
    assign o_err_total  = err_total_q;

endmodule

// File: tb/tb_rx_link_control.sv
// Directed bench for rx_link_control: CGS, ILA timing, data qualification,
// error and request driven resync, asynchronous reset.
module tb_rx_link_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_clk, lmfc_clk;
    logic [7:0] i_octet;
    logic       i_is_k, i_code_err, i_octet_valid, i_sync_request;
    logic [7:0] i_ila_multiframe_length;
    logic       o_sync_n, o_ila_valid, o_data_valid;
    logic [3:0] o_rx_state;
    logic [7:0] o_data, o_err_total;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rx_link_control dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .frame_clk               (frame_clk),
        .lmfc_clk                (lmfc_clk),
        .i_octet                 (i_octet),
        .i_is_k                  (i_is_k),
        .i_code_err              (i_code_err),
        .i_octet_valid           (i_octet_valid),
        .i_sync_request          (i_sync_request),
        .i_ila_multiframe_length (i_ila_multiframe_length),
        .o_sync_n                (o_sync_n),
        .o_rx_state              (o_rx_state),
        .o_ila_valid             (o_ila_valid),
        .o_data_valid            (o_data_valid),
        .o_data                  (o_data),
        .o_err_total             (o_err_total)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive one cycle of inputs, then sample #1 after the capturing edge.
    task automatic cyc(input logic v, input logic k, input logic e, input logic [7:0] oct,
                       input logic fr, input logic lm, input logic rq);
        i_octet_valid  = v;
        i_is_k         = k;
        i_code_err     = e;
        i_octet        = oct;
        frame_clk      = fr;
        lmfc_clk       = lm;
        i_sync_request = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic fr);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, fr, 1'b0, 1'b0);
    endtask

    task automatic kch(input logic fr);
        cyc(1'b1, 1'b1, 1'b0, 8'hBC, fr, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_ila_multiframe_length = 8'd3;
        frame_clk = 0; lmfc_clk = 0; i_octet = 0; i_is_k = 0;
        i_code_err = 0; i_octet_valid = 0; i_sync_request = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sync_n",  o_sync_n, 0);
        check("rst_state",   o_rx_state, 4'b0001);
        check("rst_ila_vld", o_ila_valid, 0);
        check("rst_dat_vld", o_data_valid, 0);
        check("rst_data",    o_data, 0);
        check("rst_errtot",  o_err_total, 0);
        rst_n = 1'b1;

        // 1: frames first, then 4 K; exit on the edge after k_cnt reaches 4
        repeat (5) idle(1'b1);
        repeat (3) kch(1'b0);
        check("t1_after3k", o_sync_n, 0);
        kch(1'b0);
        check("t1_after4k", o_sync_n, 0);
        idle(1'b0);
        check("t1_sync_up", o_sync_n, 1);
        check("t1_state",   o_rx_state, 4'b0010);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t1_req_state", o_rx_state, 4'b0001);
        check("t1_req_sync",  o_sync_n, 0);

        // 2: a data octet after 3 K restarts the K count
        repeat (5) idle(1'b1);
        repeat (3) kch(1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        check("t2_data", o_data, 8'h55);
        repeat (3) kch(1'b0);
        idle(1'b0);
        check("t2_after3k", o_rx_state, 4'b0001);
        kch(1'b0);
        idle(1'b0);
        check("t2_state", o_rx_state, 4'b0010);
        check("t2_sync",  o_sync_n, 1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t2_req_state", o_rx_state, 4'b0001);

        // 3: K complete before SYNC~ minimum time has elapsed
        repeat (4) kch(1'b0);
        repeat (4) idle(1'b1);
        check("t3_4frames", o_sync_n, 0);
        idle(1'b1);
        check("t3_5th_frame", o_sync_n, 0);
        idle(1'b0);
        check("t3_sync_up", o_sync_n, 1);

        // 4: ILA of 4 multiframes (length field 3)
        kch(1'b0);
        check("t4_k_in_check", o_rx_state, 4'b0010);
        i_ila_multiframe_length = 8'd3;
        cyc(1'b1, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0);
        check("t4_ila_state", o_rx_state, 4'b0100);
        check("t4_ila_valid", o_ila_valid, 1);
        idle(1'b0);
        check("t4_ila_idle", o_ila_valid, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), 1'b0, 1'b1, 1'b0);
            check("t4_ila_hold", o_rx_state, 4'b0100);
        end
        cyc(1'b1, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0);
        check("t4_data_state", o_rx_state, 4'b1000);
        check("t4_dvalid",     o_data_valid, 1);
        check("t4_ila_off",    o_ila_valid, 0);
        idle(1'b0);
        check("t4_dvalid_idle", o_data_valid, 0);
        cyc(1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        check("t4_dvalid2", o_data_valid, 1);
        check("t4_data",    o_data, 8'hA5);

        // 5: broken error runs tolerated, third consecutive error resyncs
        repeat (2) cyc(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        check("t5_err_dvalid", o_data_valid, 0);
        cyc(1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        check("t5_hold_data", o_rx_state, 4'b1000);
        check("t5_errtot4",   o_err_total, 8'd4);
        cyc(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        check("t5_resync", o_rx_state, 4'b0001);
        check("t5_sync_n", o_sync_n, 0);
        check("t5_errtot", o_err_total, 8'd5);

        // 6: back to DATA with a 1-multiframe ILA, then request + error
        repeat (5) idle(1'b1);
        repeat (4) kch(1'b0);
        idle(1'b0);
        check("t6_check", o_rx_state, 4'b0010);
        i_ila_multiframe_length = 8'd0;
        cyc(1'b1, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h44, 1'b0, 1'b1, 1'b0);
        check("t6_data", o_rx_state, 4'b1000);
        cyc(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        check("t6_req_state", o_rx_state, 4'b0001);
        check("t6_errtot",    o_err_total, 8'd6);
        for (int i = 0; i < 10; i++) begin
            kch((i % 2) == 0);
            check("t6_sync_min", o_sync_n, (i == 9) ? 1 : 0);
        end

        // Asynchronous reset away from the clock edge
        #2 rst_n = 1'b0;
        #1;
        check("arst_sync_n", o_sync_n, 0);
        check("arst_state",  o_rx_state, 4'b0001);
        check("arst_errtot", o_err_total, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1'b0);
        check("arst_after", o_rx_state, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
